fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 24 ++
 rtl/fetch_stage.sv | 116 +++++++++++
 tb/tb_fetch_stage.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Bundle of the IF-stage control inputs, instruction-memory bus and IF/ID outputs.
// master = fetch stage, slave = surrounding pipeline / instruction memory.
interface fetch_stage_if;
    logic        stall;
    logic        jump;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [5:0]  opcode;

    modport master (
        input  stall, jump, branch_taken, branch_target, imem_rdata,
        output imem_addr, if_id_instr, if_id_pc4, if_id_valid, opcode
    );

    modport slave (
        output stall, jump, branch_taken, branch_target, imem_rdata,
        input  imem_addr, if_id_instr, if_id_pc4, if_id_valid, opcode
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS-style instruction fetch stage: PC register, IF/ID pipeline register, branch/jump redirect.
// Optional macro FETCH_PERF_EN adds fetch and stall performance counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_stage_if.master        bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]          perf_fetch_cnt,
    output logic [31:0]          perf_stall_cnt
`endif
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_plus4_s;
    logic        jump_take_s;

    assign pc_plus4_s  = pc_q + 32'd4;
    // A jump in a bubble is a stale control signal and must not redirect.
    assign jump_take_s = bus.jump & valid_q;

    // Next-state selection: branch > jump > stall > normal fetch.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (bus.branch_taken) begin
            pc_d    = {bus.branch_target[31:2], 2'b00};
            instr_d = 32'h0000_0000;
            pc4_d   = 32'h0000_0000;
            valid_d = 1'b0;
        end else if (jump_take_s) begin
            pc_d    = {pc4_q[31:28], instr_q[25:0], 2'b00};
            instr_d = 32'h0000_0000;
            pc4_d   = 32'h0000_0000;
            valid_d = 1'b0;
        end else if (bus.stall) begin
            pc_d    = pc_q;
            instr_d = instr_q;
            pc4_d   = pc4_q;
            valid_d = valid_q;
        end else begin
            pc_d    = pc_plus4_s;
            instr_d = bus.imem_rdata;
            pc4_d   = pc_plus4_s;
            valid_d = 1'b1;
        end
    end

    // PC and IF/ID register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'h0000_0000;
            pc4_q   <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.if_id_instr = instr_q;
    assign bus.if_id_pc4   = pc4_q;
    assign bus.if_id_valid = valid_q;
    assign bus.opcode      = instr_q[31:26];

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        fetch_s, stall_s;

    assign fetch_s = ~bus.branch_taken & ~jump_take_s & ~bus.stall;
    assign stall_s = ~bus.branch_taken & ~jump_take_s &  bus.stall;

    // Counter next-state; both counters wrap naturally at 2^32.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (fetch_s) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end else begin
            fetch_cnt_d = fetch_cnt_q;
        end
        if (stall_s) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'h0000_0000;
            stall_cnt_q <= 32'h0000_0000;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: driver pushes hand-computed expectations, monitor pops and compares.
module tb_fetch_stage;

    logic clk;
    logic rst_n;

    fetch_stage_if bus();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] fc;
        logic [31:0] sc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    event chk_ev;

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small instruction memory with combinational read.
    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'h0000_0000: imem = 32'h2008_0005;
            32'h0000_0004: imem = 32'h0C00_0010;
            32'h0000_0040: imem = 32'h8C09_0000;
            32'h0000_0120: imem = 32'h1109_FFFE;
            32'hFFFF_FFFC: imem = 32'h2010_0007;
            default:       imem = 32'h0000_0000;
        endcase
    endfunction

    assign bus.imem_rdata = imem(bus.imem_addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compare every queued expectation when outputs are stable.
    initial begin
        forever begin
            @(negedge clk or chk_ev);
            while (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, ".pc"},     bus.imem_addr,   e.pc);
                chk({e.name, ".instr"},  bus.if_id_instr, e.instr);
                chk({e.name, ".pc4"},    bus.if_id_pc4,   e.pc4);
                chk({e.name, ".valid"},  {31'd0, bus.if_id_valid}, {31'd0, e.valid});
                chk({e.name, ".opcode"}, {26'd0, bus.opcode},      {26'd0, e.instr[31:26]});
`ifdef FETCH_PERF_EN
                chk({e.name, ".fcnt"},   perf_fetch_cnt,  e.fc);
                chk({e.name, ".scnt"},   perf_stall_cnt,  e.sc);
`endif
            end
        end
    end

    task automatic push(input string nm, input logic [31:0] e_pc, input logic [31:0] e_in,
                        input logic [31:0] e_p4, input logic e_v,
                        input logic [31:0] e_fc, input logic [31:0] e_sc);
        exp_t e;
        e.name = nm; e.pc = e_pc; e.instr = e_in; e.pc4 = e_p4;
        e.valid = e_v; e.fc = e_fc; e.sc = e_sc;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs (called at a negedge), queue the post-edge expectation.
    task automatic step(input string nm, input logic st, input logic jp, input logic br,
                        input logic [31:0] bt, input logic [31:0] e_pc, input logic [31:0] e_in,
                        input logic [31:0] e_p4, input logic e_v,
                        input logic [31:0] e_fc, input logic [31:0] e_sc);
        bus.stall         = st;
        bus.jump          = jp;
        bus.branch_taken  = br;
        bus.branch_target = bt;
        @(posedge clk);
        #1;
        push(nm, e_pc, e_in, e_p4, e_v, e_fc, e_sc);
        @(negedge clk);
    endtask

    // Directed stimulus.
    initial begin
        rst_n             = 1'b0;
        bus.stall         = 1'b0;
        bus.jump          = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'h0000_0000;
        #1;
        push("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0, 32'd0);
        -> chk_ev;
        @(negedge clk);
        rst_n = 1'b1;

        //   name        st    jp    br    target         pc             instr          pc4           v     fc     sc
        step("fetch0",   1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0004, 32'h2008_0005, 32'h0000_0004, 1'b1, 32'd1, 32'd0);
        step("fetch4",   1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0008, 32'h0C00_0010, 32'h0000_0008, 1'b1, 32'd2, 32'd0);
        step("stall1",   1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_0008, 32'h0C00_0010, 32'h0000_0008, 1'b1, 32'd2, 32'd1);
        step("stall2",   1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_0008, 32'h0C00_0010, 32'h0000_0008, 1'b1, 32'd2, 32'd2);
        step("stall3",   1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_0008, 32'h0C00_0010, 32'h0000_0008, 1'b1, 32'd2, 32'd3);
        step("jump",     1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_0040, 32'h0,         32'h0,         1'b0, 32'd2, 32'd3);
        step("jmpbub",   1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_0044, 32'h8C09_0000, 32'h0000_0044, 1'b1, 32'd3, 32'd3);
        step("brall",    1'b1, 1'b1, 1'b1, 32'h0000_0123, 32'h0000_0120, 32'h0,         32'h0,         1'b0, 32'd3, 32'd3);
        step("fetch120", 1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0124, 32'h1109_FFFE, 32'h0000_0124, 1'b1, 32'd4, 32'd3);
        step("brtop",    1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b0, 32'd4, 32'd3);
        step("wrap",     1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0000, 32'h2010_0007, 32'h0000_0000, 1'b1, 32'd5, 32'd3);
        step("refetch0", 1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0004, 32'h2008_0005, 32'h0000_0004, 1'b1, 32'd6, 32'd3);

        // Asynchronous reset in the middle of a cycle.
        #2;
        rst_n = 1'b0;
        #1;
        push("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0, 32'd0);
        -> chk_ev;
        @(negedge clk);

        // Pending stall/branch/jump while in reset must be discarded.
        step("rst_hold", 1'b1, 1'b1, 1'b1, 32'h0000_0500, 32'h0,         32'h0,         32'h0,         1'b0, 32'd0, 32'd0);
        rst_n = 1'b1;
        step("post_rst", 1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0004, 32'h2008_0005, 32'h0000_0004, 1'b1, 32'd1, 32'd0);
        step("jmp_stl",  1'b1, 1'b1, 1'b0, 32'h0,         32'h0020_0014, 32'h0,         32'h0,         1'b0, 32'd1, 32'd0);

        for (int i = 0; i < 5; i++) begin
            if (exp_q.size() > 0) @(negedge clk);
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
